// File: rtl/pmem_rr_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the icache
// and the dcache. A granted request is captured so the memory sees stable,
// registered strobes, address and write data for the whole transaction.
module pmem_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q;
  logic              last_q;
  logic              op_is_write_q;
  logic              req_i, req_d;
  logic              grant;
  logic              winner;
  logic              win_write;
  logic [ADDR_W-1:0] win_addr;
  logic [LINE_W-1:0] win_wdata;

  // Grant counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Arbitration decision and next-state logic.
  always_comb begin
    req_i     = i_read | i_write;
    req_d     = d_read | d_write;
    grant     = (state_q == IDLE) && (req_i || req_d);
    // On a tie the port that did not win last time gets the bus.
    winner    = (req_i && req_d) ? ~last_q : req_d;
    // A write strobe takes precedence over a simultaneous read strobe.
    win_write = (winner == PORT_D) ? d_write : i_write;
    win_addr  = (winner == PORT_D) ? d_addr  : i_addr;
    win_wdata = (winner == PORT_D) ? d_wdata : i_wdata;
    state_d   = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = BUSY;
      BUSY:    if (pmem_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Captured request, memory-side strobes, read-data returns and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q       <= PORT_I;
      last_q        <= PORT_D;
      op_is_write_q <= 1'b0;
      pmem_read     <= 1'b0;
      pmem_write    <= 1'b0;
      pmem_address  <= '0;
      pmem_wdata    <= '0;
      i_rdata       <= '0;
      d_rdata       <= '0;
      i_resp        <= 1'b0;
      d_resp        <= 1'b0;
      i_grant_cnt   <= '0;
      d_grant_cnt   <= '0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q       <= winner;
            last_q        <= winner;
            op_is_write_q <= win_write;
            pmem_read     <= ~win_write;
            pmem_write    <= win_write;
            pmem_address  <= win_addr;
            pmem_wdata    <= win_wdata;
            if (winner == PORT_D) d_grant_cnt <= sat_inc(d_grant_cnt);
            else                  i_grant_cnt <= sat_inc(i_grant_cnt);
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            if (owner_q == PORT_D) begin
              d_resp <= 1'b1;
              if (!op_is_write_q) d_rdata <= pmem_rdata;
            end else begin
              i_resp <= 1'b1;
              if (!op_is_write_q) i_rdata <= pmem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
